// File: rtl/ram64_arbiter_pkg.sv
// ram64_arbiter_pkg: shared definitions for the ram64 arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (64 x 16)
//   state_e                 : sequencer state encoding
package ram64_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

endpackage

// File: rtl/ram64_arbiter_if.sv
// ram64_arbiter_if: bundles both requester ports and the ram64 pin-side signals.
//   req*/we*/addr*/wdata*  : requester -> arbiter
//   ack*/rdata*/init_done  : arbiter -> requester (registered)
//   ram_address/ram_data_in/ram_write_enable : arbiter -> ram64
//   ram_data_out                             : ram64 -> arbiter
// Modports: slave = arbiter side, master = requesters plus RAM owner.
interface ram64_arbiter_if
    import ram64_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              init_done;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;
    logic [DATA_W-1:0] ram_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
        output ack0, ack1, rdata0, rdata1, init_done,
        output ram_address, ram_data_in, ram_write_enable
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
        input  ack0, ack1, rdata0, rdata1, init_done,
        input  ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/ram64_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   elig[1:0]   : eligible requesters
//   last        : id of the most recent winner
//   grant_valid : some requester is eligible
//   grant_id    : winning requester (meaningful only with grant_valid)
module rr_pick2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);
    assign grant_valid = |elig;
    // On a tie the requester that did not win last time goes next.
    assign grant_id    = (elig == 2'b11) ? ~last : elig[1];
endmodule

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: round-robin arbiter/sequencer in front of one ram64.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : ram64_arbiter_if.slave (requester ports, acks, RAM pins)
// After reset it optionally zero-fills the RAM, then grants one single-word
// access per clock. Acks and rdata are registered; RAM pins are combinational.
module ram64_arbiter
    import ram64_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input logic            clk,
    input logic            rst,
    ram64_arbiter_if.slave bus
);
    localparam state_e RESET_STATE = INIT_CLEAR ? ST_INIT : ST_SERVE;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              last_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              init_done_q;

    logic [1:0]        elig;
    logic              grant_valid;
    logic              grant_id;
    logic              grant;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;

    // A request still held high during its own ack cycle is masked so it is
    // not served twice.
    assign elig = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};

    rr_pick2 u_pick (
        .elig        (elig),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant = (state_q == ST_SERVE) && grant_valid;

    always_comb begin
        ram_address      = '0;
        ram_data_in      = '0;
        ram_write_enable = 1'b0;
        if (state_q == ST_INIT) begin
            ram_address      = cnt_q;
            ram_write_enable = 1'b1;
        end else if (grant) begin
            if (grant_id) begin
                ram_address      = bus.addr1;
                ram_data_in      = bus.wdata1;
                ram_write_enable = bus.we1;
            end else begin
                ram_address      = bus.addr0;
                ram_data_in      = bus.wdata0;
                ram_write_enable = bus.we0;
            end
        end
        // Never let a write reach the RAM while reset is asserted.
        if (!rst) begin
            ram_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            init_done_q <= !INIT_CLEAR;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q     <= ST_SERVE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    ack0_q <= grant && !grant_id;
                    ack1_q <= grant && grant_id;
                    if (grant) begin
                        last_q <= grant_id;
                        // Sampled at the write edge too, so write acks carry
                        // the pre-write word.
                        if (grant_id) begin
                            rdata1_q <= bus.ram_data_out;
                        end else begin
                            rdata0_q <= bus.ram_data_out;
                        end
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

    assign bus.ack0             = ack0_q;
    assign bus.ack1             = ack1_q;
    assign bus.rdata0           = rdata0_q;
    assign bus.rdata1           = rdata1_q;
    assign bus.init_done        = init_done_q;
    assign bus.ram_address      = ram_address;
    assign bus.ram_data_in      = ram_data_in;
    assign bus.ram_write_enable = ram_write_enable;
endmodule
